reflet_vga_rect_fill: RTL

Command-driven rectangle fill sequencer for the pixel write port of `reflet_VGA`, or of `reflet_VGA_bitmap` directly. It accepts one rectangle command (two corners plus RGBA colour) over a valid/ready handshake. It then emits one pixel write per clock in raster order, covering every pixel of the rectangle. It is used for screen clears, solid boxes and sprite backgrounds, so the CPU no longer issues per-pixel writes.

---
 rtl/reflet_vga_rect_fill.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reflet_vga_rect_fill.sv
// Rectangle fill sequencer: takes one corner-pair + RGBA command and streams one pixel write per clock in raster order.
// Optional macro REFLET_VGA_RECT_CLIP_EN clamps the rectangle to the visible screen and drops fully off-screen commands.
module reflet_vga_rect_fill #(
    parameter int h_size        = 640,
    parameter int v_line        = 480,
    parameter int color_depth   = 8,
    parameter int bit_reduction = 0
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       cmd_valid,
    output logic                                       cmd_ready,
    input  logic [$clog2(h_size)-bit_reduction-1:0]    cmd_x0,
    input  logic [$clog2(h_size)-bit_reduction-1:0]    cmd_x1,
    input  logic [$clog2(v_line)-bit_reduction-1:0]    cmd_y0,
    input  logic [$clog2(v_line)-bit_reduction-1:0]    cmd_y1,
    input  logic [color_depth-1:0]                     cmd_R,
    input  logic [color_depth-1:0]                     cmd_G,
    input  logic [color_depth-1:0]                     cmd_B,
    input  logic [color_depth-1:0]                     cmd_a,
    input  logic                                       abort,
    output logic                                       write_en,
    output logic [$clog2(h_size)-bit_reduction-1:0]    h_pixel,
    output logic [$clog2(v_line)-bit_reduction-1:0]    v_pixel,
    output logic [color_depth-1:0]                     R_out,
    output logic [color_depth-1:0]                     G_out,
    output logic [color_depth-1:0]                     B_out,
    output logic [color_depth-1:0]                     a_out,
    output logic                                       busy,
    output logic                                       done
);

    localparam int HW = $clog2(h_size) - bit_reduction;
    localparam int VW = $clog2(v_line) - bit_reduction;

`ifdef REFLET_VGA_RECT_CLIP_EN
    localparam logic [HW-1:0] H_MAX = HW'((h_size >> bit_reduction) - 1);
    localparam logic [VW-1:0] V_MAX = VW'((v_line >> bit_reduction) - 1);
`endif

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, state_next;

    logic [HW-1:0] x_left, x_left_next;
    logic [HW-1:0] x_right, x_right_next;
    logic [VW-1:0] y_bottom, y_bottom_next;

    logic [HW-1:0] h_pixel_next;
    logic [VW-1:0] v_pixel_next;
    logic [color_depth-1:0] r_next, g_next, b_next, a_next;
    logic write_en_next, busy_next, done_next, cmd_ready_next;

    logic [HW-1:0] xl_cmd, xr_cmd, xr_eff;
    logic [VW-1:0] yt_cmd, yb_cmd, yb_eff;
    logic          cmd_visible;

    // Corner normalization (and optional clipping) of the incoming command
    always_comb begin
        xl_cmd = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        xr_cmd = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        yt_cmd = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        yb_cmd = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
`ifdef REFLET_VGA_RECT_CLIP_EN
        cmd_visible = (xl_cmd <= H_MAX) && (yt_cmd <= V_MAX);
        xr_eff      = (xr_cmd > H_MAX) ? H_MAX : xr_cmd;
        yb_eff      = (yb_cmd > V_MAX) ? V_MAX : yb_cmd;
`else
        cmd_visible = 1'b1;
        xr_eff      = xr_cmd;
        yb_eff      = yb_cmd;
`endif
    end

    // Next-state and next-output logic; h_pixel/v_pixel double as the scan counters
    always_comb begin
        state_next     = state;
        x_left_next    = x_left;
        x_right_next   = x_right;
        y_bottom_next  = y_bottom;
        h_pixel_next   = h_pixel;
        v_pixel_next   = v_pixel;
        r_next         = R_out;
        g_next         = G_out;
        b_next         = B_out;
        a_next         = a_out;
        write_en_next  = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        cmd_ready_next = 1'b1;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    r_next = cmd_R;
                    g_next = cmd_G;
                    b_next = cmd_B;
                    a_next = cmd_a;
                    if (cmd_visible) begin
                        state_next     = FILL;
                        x_left_next    = xl_cmd;
                        x_right_next   = xr_eff;
                        y_bottom_next  = yb_eff;
                        h_pixel_next   = xl_cmd;
                        v_pixel_next   = yt_cmd;
                        write_en_next  = 1'b1;
                        busy_next      = 1'b1;
                        cmd_ready_next = 1'b0;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            FILL: begin
                // The write on the bus this cycle completes regardless of abort
                if (abort) begin
                    state_next = IDLE;
                end else if (h_pixel < x_right) begin
                    h_pixel_next   = h_pixel + HW'(1);
                    write_en_next  = 1'b1;
                    busy_next      = 1'b1;
                    cmd_ready_next = 1'b0;
                end else if (v_pixel < y_bottom) begin
                    h_pixel_next   = x_left;
                    v_pixel_next   = v_pixel + VW'(1);
                    write_en_next  = 1'b1;
                    busy_next      = 1'b1;
                    cmd_ready_next = 1'b0;
                end else begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_left    <= '0;
            x_right   <= '0;
            y_bottom  <= '0;
            h_pixel   <= '0;
            v_pixel   <= '0;
            R_out     <= '0;
            G_out     <= '0;
            B_out     <= '0;
            a_out     <= '0;
            write_en  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_next;
            x_left    <= x_left_next;
            x_right   <= x_right_next;
            y_bottom  <= y_bottom_next;
            h_pixel   <= h_pixel_next;
            v_pixel   <= v_pixel_next;
            R_out     <= r_next;
            G_out     <= g_next;
            B_out     <= b_next;
            a_out     <= a_next;
            write_en  <= write_en_next;
            busy      <= busy_next;
            done      <= done_next;
            cmd_ready <= cmd_ready_next;
        end
    end

endmodule
